// File: rtl/pipeline_ctrl_pkg.sv
// Shared pipeline control definitions: latch mode encodings and run-controller state enumeration.
package pipeline_ctrl_pkg;

  localparam logic [1:0] MODE_FROZEN = 2'b00;
  localparam logic [1:0] MODE_CONT   = 2'b01;
  localparam logic [1:0] MODE_STEP   = 2'b11;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    CONT       = 3'd1,
    STEP_WAIT  = 3'd2,
    STEP_PULSE = 3'd3,
    STEP_ACK   = 3'd4,
    HALT       = 3'd5
  } state_e;

endpackage

// File: rtl/pipeline_run_controller_sat_counter.sv
// Saturating up-counter with enable and synchronous clear; clear takes priority over enable.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         i_clk,
  input  logic         i_reset,
  input  logic         i_clear,
  input  logic         i_enable,
  output logic [W-1:0] o_count
);

  logic [W-1:0] count_r;

  // Count register: holds at all-ones instead of wrapping.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      count_r <= W'(0);
    end else if (i_clear) begin
      count_r <= W'(0);
    end else if (i_enable && (count_r != {W{1'b1}})) begin
      count_r <= count_r + W'(1);
    end else begin
      count_r <= count_r;
    end
  end

  assign o_count = count_r;

endmodule

// File: rtl/pipeline_run_controller.sv
// Run controller driving the shared pipeline latch mode / execute pulse from debug-unit commands.
// Optional watchdog halt of continuous mode: define PIPE_RUN_CTRL_WATCHDOG_EN.
module pipeline_run_controller
  import pipeline_ctrl_pkg::*;
#(
  parameter int NB_CNT    = 16,
  parameter int WDT_LIMIT = 1024
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_start_cont,
  input  logic              i_start_step,
  input  logic              i_step,
  input  logic              i_restart,
  input  logic              i_EOF_flag,
  output logic [1:0]        o_pipeline_mode,
  output logic              o_execute_instruct,
  output logic              o_halted,
  output logic              o_step_done,
  output logic [NB_CNT-1:0] o_adv_count,
  output logic              o_wdt_timeout
);

`ifdef PIPE_RUN_CTRL_WATCHDOG_EN
  localparam logic WDT_EN = 1'b1;
`else
  localparam logic WDT_EN = 1'b0;
`endif
  localparam logic [31:0] WDT_LIMIT_U = 32'(WDT_LIMIT);

  state_e            state_r, next_state_s;
  logic [1:0]        mode_r, mode_s;
  logic              exec_r, exec_s;
  logic              halted_r, halted_s;
  logic              done_r, done_s;
  logic              cnt_en_s;
  logic              wdt_hit_s;
  logic [NB_CNT-1:0] count_s;
  logic [31:0]       count_next_s;

  // A saturated counter cannot step onto the limit, so it never trips the watchdog.
  assign count_next_s = 32'(count_s) + 32'd1;
  assign wdt_hit_s    = WDT_EN && (count_next_s == WDT_LIMIT_U) && !(&count_s);

  // Next-state logic; restart overrides everything, EOF overrides the remaining commands.
  always_comb begin
    next_state_s = state_r;
    if (i_restart) begin
      next_state_s = IDLE;
    end else begin
      case (state_r)
        IDLE: begin
          if (i_start_cont)      next_state_s = CONT;
          else if (i_start_step) next_state_s = STEP_WAIT;
          else                   next_state_s = IDLE;
        end
        CONT: begin
          if (i_EOF_flag)        next_state_s = HALT;
          else if (wdt_hit_s)    next_state_s = HALT;
          else if (i_start_cont) next_state_s = CONT;
          else if (i_start_step) next_state_s = STEP_WAIT;
          else                   next_state_s = CONT;
        end
        STEP_WAIT: begin
          if (i_EOF_flag)        next_state_s = HALT;
          else if (i_start_cont) next_state_s = CONT;
          else if (i_start_step) next_state_s = STEP_WAIT;
          else if (i_step)       next_state_s = STEP_PULSE;
          else                   next_state_s = STEP_WAIT;
        end
        STEP_PULSE: next_state_s = STEP_ACK;
        STEP_ACK:   next_state_s = STEP_WAIT;
        HALT:       next_state_s = HALT;
        default:    next_state_s = IDLE;
      endcase
    end
  end

  // Output decode from the next state so the registered outputs line up with the state register.
  always_comb begin
    mode_s   = MODE_FROZEN;
    exec_s   = 1'b0;
    halted_s = 1'b0;
    done_s   = 1'b0;
    case (next_state_s)
      IDLE:       mode_s = MODE_FROZEN;
      CONT:       mode_s = MODE_CONT;
      STEP_WAIT:  mode_s = MODE_STEP;
      STEP_PULSE: begin
        mode_s = MODE_STEP;
        exec_s = 1'b1;
      end
      STEP_ACK: begin
        mode_s = MODE_STEP;
        done_s = 1'b1;
      end
      HALT: begin
        mode_s   = MODE_FROZEN;
        halted_s = 1'b1;
      end
      default: mode_s = MODE_FROZEN;
    endcase
  end

  // State and output registers.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_r  <= IDLE;
      mode_r   <= MODE_FROZEN;
      exec_r   <= 1'b0;
      halted_r <= 1'b0;
      done_r   <= 1'b0;
    end else begin
      state_r  <= next_state_s;
      mode_r   <= mode_s;
      exec_r   <= exec_s;
      halted_r <= halted_s;
      done_r   <= done_s;
    end
  end

  // The latches advance on any edge where they currently see continuous mode or a step pulse.
  assign cnt_en_s = (mode_r == MODE_CONT) || ((mode_r == MODE_STEP) && exec_r);

  sat_counter #(
    .W (NB_CNT)
  ) u_adv_cnt (
    .i_clk    (i_clk),
    .i_reset  (i_reset),
    .i_clear  (i_restart),
    .i_enable (cnt_en_s),
    .o_count  (count_s)
  );

`ifdef PIPE_RUN_CTRL_WATCHDOG_EN
  logic wdt_r;

  // Sticky watchdog flag, set only when the watchdog itself forces the halt.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      wdt_r <= 1'b0;
    end else if (i_restart) begin
      wdt_r <= 1'b0;
    end else if ((state_r == CONT) && !i_EOF_flag && wdt_hit_s) begin
      wdt_r <= 1'b1;
    end else begin
      wdt_r <= wdt_r;
    end
  end

  assign o_wdt_timeout = wdt_r;
`else
  assign o_wdt_timeout = 1'b0;
`endif

  assign o_pipeline_mode    = mode_r;
  assign o_execute_instruct = exec_r;
  assign o_halted           = halted_r;
  assign o_step_done        = done_r;
  assign o_adv_count        = count_s;

endmodule

// File: tb/tb_pipeline_run_controller.sv
// Directed self-checking bench for pipeline_run_controller (default and NB_CNT=4 instances).
module tb_pipeline_run_controller;

`ifdef PIPE_RUN_CTRL_WATCHDOG_EN
  localparam logic WDT_ON = 1'b1;
`else
  localparam logic WDT_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, start_cont, start_step, step, restart, eof;
  logic [1:0]  mode;
  logic        exec_o, halted, done, wdt;
  logic [15:0] count;

  logic        rst4, start_cont4, zero4;
  logic [1:0]  mode4;
  logic        exec4, halted4, done4, wdt4;
  logic [3:0]  count4;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pipeline_run_controller #(.NB_CNT(16), .WDT_LIMIT(8)) dut (
    .i_clk              (clk),
    .i_reset            (rst),
    .i_start_cont       (start_cont),
    .i_start_step       (start_step),
    .i_step             (step),
    .i_restart          (restart),
    .i_EOF_flag         (eof),
    .o_pipeline_mode    (mode),
    .o_execute_instruct (exec_o),
    .o_halted           (halted),
    .o_step_done        (done),
    .o_adv_count        (count),
    .o_wdt_timeout      (wdt)
  );

  pipeline_run_controller #(.NB_CNT(4), .WDT_LIMIT(1024)) dut4 (
    .i_clk              (clk),
    .i_reset            (rst4),
    .i_start_cont       (start_cont4),
    .i_start_step       (zero4),
    .i_step             (zero4),
    .i_restart          (zero4),
    .i_EOF_flag         (zero4),
    .o_pipeline_mode    (mode4),
    .o_execute_instruct (exec4),
    .o_halted           (halted4),
    .o_step_done        (done4),
    .o_adv_count        (count4),
    .o_wdt_timeout      (wdt4)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk(input string tag, input logic [1:0] m, input logic e, input logic h,
                     input logic d, input logic [15:0] c, input logic w);
    check({tag, ".mode"},   32'(mode),   32'(m));
    check({tag, ".exec"},   32'(exec_o), 32'(e));
    check({tag, ".halted"}, 32'(halted), 32'(h));
    check({tag, ".done"},   32'(done),   32'(d));
    check({tag, ".count"},  32'(count),  32'(c));
    check({tag, ".wdt"},    32'(wdt),    32'(w));
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; rst4 = 1'b1; zero4 = 1'b0; start_cont4 = 1'b0;
    start_cont = 1'b0; start_step = 1'b0; step = 1'b0; restart = 1'b0; eof = 1'b0;
    #12;
    chk("reset", 2'b00, 1'b0, 1'b0, 1'b0, 16'd0, 1'b0);
    tick();
    rst = 1'b0;

    // continuous run ended by EOF
    start_cont = 1'b1; tick(); start_cont = 1'b0;
    chk("t1_start", 2'b01, 1'b0, 1'b0, 1'b0, 16'd0, 1'b0);
    repeat (3) tick();
    chk("t1_run", 2'b01, 1'b0, 1'b0, 1'b0, 16'd3, 1'b0);
    start_cont = 1'b1; start_step = 1'b1; tick(); start_cont = 1'b0; start_step = 1'b0;
    chk("t1_prio", 2'b01, 1'b0, 1'b0, 1'b0, 16'd4, 1'b0);
    repeat (3) tick();
    eof = 1'b1; tick(); eof = 1'b0;
    chk("t1_eof", 2'b00, 1'b0, 1'b1, 1'b0, 16'd8, 1'b0);

    // HALT ignores everything but restart
    start_cont = 1'b1; tick(); start_cont = 1'b0;
    chk("t4_cont_ign", 2'b00, 1'b0, 1'b1, 1'b0, 16'd8, 1'b0);
    step = 1'b1; start_step = 1'b1; tick(); step = 1'b0; start_step = 1'b0;
    chk("t4_step_ign", 2'b00, 1'b0, 1'b1, 1'b0, 16'd8, 1'b0);
    restart = 1'b1; tick(); restart = 1'b0;
    chk("t4_restart", 2'b00, 1'b0, 1'b0, 1'b0, 16'd0, 1'b0);

    // stepwise: pulse, dropped steps in PULSE and ACK
    start_step = 1'b1; tick(); start_step = 1'b0;
    chk("t2_mode", 2'b11, 1'b0, 1'b0, 1'b0, 16'd0, 1'b0);
    step = 1'b1; tick();
    chk("t2_pulse1", 2'b11, 1'b1, 1'b0, 1'b0, 16'd0, 1'b0);
    tick(); step = 1'b0;
    chk("t2_ack1", 2'b11, 1'b0, 1'b0, 1'b1, 16'd1, 1'b0);
    tick();
    chk("t2_wait1", 2'b11, 1'b0, 1'b0, 1'b0, 16'd1, 1'b0);
    tick();
    chk("t2_idle", 2'b11, 1'b0, 1'b0, 1'b0, 16'd1, 1'b0);
    step = 1'b1; tick(); step = 1'b0;
    chk("t2_pulse2", 2'b11, 1'b1, 1'b0, 1'b0, 16'd1, 1'b0);
    tick();
    chk("t2_ack2", 2'b11, 1'b0, 1'b0, 1'b1, 16'd2, 1'b0);
    step = 1'b1; tick(); step = 1'b0;
    chk("t2_ack_drop", 2'b11, 1'b0, 1'b0, 1'b0, 16'd2, 1'b0);

    // EOF beats step in STEP_WAIT
    step = 1'b1; eof = 1'b1; tick(); step = 1'b0; eof = 1'b0;
    chk("t3_halt", 2'b00, 1'b0, 1'b1, 1'b0, 16'd2, 1'b0);
    tick();
    chk("t3_hold", 2'b00, 1'b0, 1'b1, 1'b0, 16'd2, 1'b0);

    // restart beats start_cont, then watchdog run (limit 8)
    restart = 1'b1; start_cont = 1'b1; tick(); restart = 1'b0; start_cont = 1'b0;
    chk("t6_prio", 2'b00, 1'b0, 1'b0, 1'b0, 16'd0, 1'b0);
    start_cont = 1'b1; tick(); start_cont = 1'b0;
    repeat (7) tick();
    chk("t6_pre", 2'b01, 1'b0, 1'b0, 1'b0, 16'd7, 1'b0);
    tick();
    chk("t6_limit", WDT_ON ? 2'b00 : 2'b01, 1'b0, WDT_ON, 1'b0, 16'd8, WDT_ON);
    repeat (3) tick();
    chk("t6_hold", WDT_ON ? 2'b00 : 2'b01, 1'b0, WDT_ON, 1'b0, WDT_ON ? 16'd8 : 16'd11, WDT_ON);
    restart = 1'b1; tick(); restart = 1'b0;
    chk("t6_restart", 2'b00, 1'b0, 1'b0, 1'b0, 16'd0, 1'b0);

    // NB_CNT=4 saturation and asynchronous reset
    rst4 = 1'b0;
    start_cont4 = 1'b1; tick(); start_cont4 = 1'b0;
    check("t5_mode", 32'(mode4), 32'(2'b01));
    check("t5_cnt0", 32'(count4), 32'd0);
    repeat (20) tick();
    check("t5_sat", 32'(count4), 32'd15);
    check("t5_mode_run", 32'(mode4), 32'(2'b01));
    check("t5_wdt", 32'(wdt4), 32'd0);
    #1 rst4 = 1'b1;
    #1;
    check("t5_async_mode", 32'(mode4), 32'd0);
    check("t5_async_cnt", 32'(count4), 32'd0);
    check("t5_async_flags", 32'({exec4, halted4, done4, wdt4}), 32'd0);
    tick();
    check("t5_held_mode", 32'(mode4), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipeline_run_controller.md
Name: pipeline_run_controller

Overview:
Sequences the pipeline latches (IF/ID, ID/EX, EX/MEM, MEM/WB) by generating the shared pipeline_mode and execute_instruct controls those latches consume.
- Supports idle/frozen, continuous and stepwise operation, driven by single-cycle commands from the debug unit.
- Halts the pipeline when the end-of-program (EOF) flag reaches the MEM/WB latch output.
- Keeps a saturating count of pipeline advances for the debug unit to report.

Parameters:
- NB_CNT, 16, width of the advance counter.
- WDT_LIMIT, 1024, advance count at which the watchdog halts continuous mode (used only with the optional feature).

Ports:
- i_clk  in  1  system clock
- i_reset  in  1  asynchronous, active-high reset
- i_start_cont  in  1  one-cycle command: enter continuous mode
- i_start_step  in  1  one-cycle command: enter stepwise mode
- i_step  in  1  one-cycle command: advance the pipeline by one instruction (stepwise mode only)
- i_restart  in  1  one-cycle command: return to idle, clear counter and flags
- i_EOF_flag  in  1  EOF flag from the MEM/WB latch output
- o_pipeline_mode  out  2  00 frozen, 01 continuous, 11 stepwise (to all latches)
- o_execute_instruct  out  1  one-cycle advance pulse in stepwise mode
- o_halted  out  1  high while in HALT
- o_step_done  out  1  one-cycle pulse the cycle after each advance pulse
- o_adv_count  out  NB_CNT  number of cycles in which the latches advanced (saturating)
- o_wdt_timeout  out  1  sticky watchdog flag

Behaviour:
- Reset (asynchronous, active-high) forces the following, regardless of current state:
  - state IDLE; o_pipeline_mode=00; o_execute_instruct=0; o_halted=0; o_step_done=0; o_adv_count=0; o_wdt_timeout=0.
- All outputs are registered.
- Command priority within a cycle: i_restart > i_start_cont > i_start_step > i_step. Only the highest-priority command is acted on; the rest are dropped.
- States and outputs:
  - IDLE: mode 00.
  - CONT: mode 01.
  - STEP_WAIT: mode 11, exec 0.
  - STEP_PULSE: mode 11, exec 1.
  - STEP_ACK: mode 11, exec 0, o_step_done=1.
  - HALT: mode 00, o_halted=1.
- Transitions:
  - IDLE: start_cont -> CONT; start_step -> STEP_WAIT; step ignored.
  - CONT: i_EOF_flag=1 -> HALT; start_step -> STEP_WAIT (switch to stepwise without flush).
  - STEP_WAIT: i_EOF_flag=1 -> HALT (takes precedence over step); step -> STEP_PULSE; start_cont -> CONT.
  - STEP_PULSE: unconditionally -> STEP_ACK. Commands received in this cycle are dropped.
  - STEP_ACK: -> STEP_WAIT. A step in this cycle is dropped; a step is accepted only in STEP_WAIT.
  - HALT: only i_restart leaves, -> IDLE. start_cont, start_step and step are ignored.
  - i_restart in any state -> IDLE, clears o_adv_count and o_wdt_timeout.
- Latency:
  - Command sampled at edge N -> new mode visible from cycle N+1.
  - Step sampled in STEP_WAIT at edge N -> exec high for exactly cycle N+1 -> step_done high for cycle N+2 -> back in STEP_WAIT at N+3.
  - EOF seen in CONT at edge N -> mode 00 from cycle N+1. The latches advance once more at edge N because mode was still 01 during cycle N.
- Counter:
  - Increments on every edge where the presented outputs are mode 01, or mode 11 with exec 1.
  - Saturates at 2^NB_CNT-1 (no wrap).
  - Holds its value in HALT and IDLE; cleared only by reset or restart.

Optional Feature:
- Macro: PIPE_RUN_CTRL_WATCHDOG_EN.
- Defined:
  - In CONT, when an increment would make o_adv_count equal WDT_LIMIT and i_EOF_flag=0, go to HALT and set o_wdt_timeout=1.
  - o_wdt_timeout stays set until restart or reset.
  - Stepwise mode is never timed out.
- Undefined: o_wdt_timeout is tied to 0, and WDT_LIMIT is unused.

Decomposition:
- Shared package pipeline_ctrl_pkg holds:
  - mode constants MODE_FROZEN=2'b00, MODE_CONT=2'b01, MODE_STEP=2'b11 (also used by all latches);
  - the state enumeration, 3-bit: IDLE=0, CONT=1, STEP_WAIT=2, STEP_PULSE=3, STEP_ACK=4, HALT=5.
- One sub-module, sat_counter: parameterised saturating counter with enable and synchronous clear. It is used for o_adv_count.

Test Plan:
1. Reset, then start_cont at cycle 2, EOF high at cycle 10 -> mode=01 in cycles 3..10, mode=00 and halted=1 from cycle 11, adv_count=8.
2. start_step, then step pulses at cycles 5, 6 and 9 -> exec high at cycles 6 and 10 only (step at 6 dropped in STEP_PULSE), step_done at 7 and 11, adv_count=2.
3. In STEP_WAIT, step and EOF asserted in the same cycle -> HALT, exec never pulses, adv_count unchanged.
4. In HALT: start_cont, then step, then restart -> first two ignored; after restart mode=00, halted=0, adv_count=0.
5. NB_CNT=4, run continuous for 20 cycles without EOF -> adv_count holds at 15. Reset asserted mid-run -> all outputs 0 immediately, without waiting for a clock edge.
6. With PIPE_RUN_CTRL_WATCHDOG_EN and WDT_LIMIT=8, continuous mode without EOF -> HALT once adv_count=8, o_wdt_timeout=1 until restart. Without the macro, same run -> still in CONT, o_wdt_timeout=0.
